// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op encodings, FSM states, size/sign decode.
package lsu_pkg;

    typedef enum logic [2:0] {
        OpLb  = 3'd0,
        OpLh  = 3'd1,
        OpLw  = 3'd2,
        OpSw  = 3'd3,
        OpLbu = 3'd4,
        OpLhu = 3'd5,
        OpSb  = 3'd6,
        OpSh  = 3'd7
    } lsu_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StRmwRd,
        StRmwWr,
        StResp
    } lsu_state_e;

    // Access size in bytes: 1, 2 or 4.
    function automatic logic [2:0] op_size(lsu_op_t op);
        case (op)
            OpLb, OpLbu, OpSb: op_size = 3'd1;
            OpLh, OpLhu, OpSh: op_size = 3'd2;
            default:           op_size = 3'd4;
        endcase
    endfunction

    function automatic logic op_is_store(lsu_op_t op);
        return (op == OpSb) || (op == OpSh) || (op == OpSw);
    endfunction

    function automatic logic op_is_signed(lsu_op_t op);
        return (op == OpLb) || (op == OpLh);
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Byte/half lane logic: extract-and-extend for loads, lane merge for sub-word stores.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sgn;

    always_comb begin
        byte_sel  = mem_word[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
        sgn       = op_is_signed(op);
        load_data = mem_word;
        merged    = mem_word;
        case (op_size(op))
            3'd1: begin
                load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            3'd2: begin
                load_data = {{16{sgn & half_sel[15]}}, half_sel};
                if (addr_lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_data = mem_word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/loadstore_unit.sv
// MIPS load/store unit driving a word-wide data memory; sub-word stores use read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses raise resp_err instead of being aligned.
module loadstore_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W:0] MemLimit = (ADDR_W+1)'(MEM_BYTES);

    lsu_state_e        state_q, state_d;
    lsu_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    lsu_op_t           req_op_t;
    logic [2:0]        req_size;
    logic [ADDR_W:0]   end_addr;
    logic [ADDR_W-1:0] align_addr;
    logic              addr_err;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    // Range check uses the raw address so a straddling access is caught in both builds.
    always_comb begin
        req_op_t   = lsu_op_t'(req_op);
        req_size   = op_size(req_op_t);
        end_addr   = {1'b0, req_addr} + (ADDR_W+1)'(req_size);
        align_addr = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        addr_err   = (end_addr > MemLimit) ||
                     (req_size == 3'd2 && req_addr[0]) ||
                     (req_size == 3'd4 && req_addr[1:0] != 2'b00);
`else
        addr_err   = (end_addr > MemLimit);
        if (req_size != 3'd1) align_addr[0] = 1'b0;
        if (req_size == 3'd4) align_addr[1] = 1'b0;
`endif
    end

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_lane_mux u_lane_mux (
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .mem_word  (mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpLb;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op_t;
                    addr_d  = align_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = addr_err;
                    if (addr_err) begin
                        state_d = StResp;
                    end else if (req_op_t == OpSw) begin
                        state_d = StStore;
                    end else if (op_is_store(req_op_t)) begin
                        state_d = StRmwRd;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_data;
                state_d = StResp;
            end
            StStore: state_d = StResp;
            StRmwRd: begin
                wdata_d = merged;
                state_d = StRmwWr;
            end
            StRmwWr: state_d = StResp;
            StResp: begin
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        case (state_q)
            StLoad, StRmwRd: mem_addr = word_addr;
            StStore, StRmwWr: begin
                mem_addr  = word_addr;
                mem_wdata = wdata_q;
                mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_loadstore_unit.sv
// Directed bench for loadstore_unit with a byte-array memory model and a response scoreboard.
module tb_loadstore_unit;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, SW = 3'd3;
    localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, SB = 3'd6, SH = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem[0:127];
    logic [6:0]  ra;
    int          we_cnt = 0;
    int          we_base = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    loadstore_unit #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign ra = {mem_addr[6:2], 2'b00};
    assign mem_rdata = {mem[ra + 7'd3], mem[ra + 7'd2], mem[ra + 7'd1], mem[ra]};

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            we_cnt = we_cnt + 1;
            for (int b = 0; b < 4; b++) mem[ra + 7'(b)] = mem_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] mword(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at #1 after a posedge with the DUT idle; returns #1 after the accept edge.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        we_base = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int exp_lat, input int exp_we);
        exp_t e;
        int   cycles;
        cycles = 1;
        while (resp_valid !== 1'b1 && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk({tag, " latency"}, 32'(cycles), 32'(exp_lat));
        e = sb.pop_front();
        chk({tag, " rdata"}, resp_rdata, e.rdata);
        chk({tag, " err"}, 32'(resp_err), 32'(e.err));
        chk({tag, " writes"}, 32'(we_cnt - we_base), 32'(exp_we));
    endtask

    task automatic finish_resp(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, " resp_valid drop"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee,
                          input int lat, input int nwe);
        issue(tag, op, addr, wd, er, ee);
        wait_resp(tag, lat, nwe);
        finish_resp(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h8899AABB;
        {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} = 32'hCAFEF00D;

        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_req("LB 11", LB, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
        do_req("LBU 11", LBU, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0);
        do_req("LH 12", LH, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
        do_req("LHU 12", LHU, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0);
        do_req("LB 10", LB, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0);

        do_req("SW 20", SW, 32'h20, 32'h12345678, 32'h0, 1'b0, 2, 1);
        chk("mem 20 after SW", mword(32'h20), 32'h12345678);
        do_req("LW 20", LW, 32'h20, 32'h0, 32'h12345678, 1'b0, 2, 0);

        do_req("SB 22", SB, 32'h22, 32'hFFFFFFEE, 32'h0, 1'b0, 3, 1);
        chk("mem 20 after SB", mword(32'h20), 32'h12EE5678);
        do_req("SH 20", SH, 32'h20, 32'h0000BEEF, 32'h0, 1'b0, 3, 1);
        chk("mem 20 after SH", mword(32'h20), 32'h12EEBEEF);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req("LW 22 trap", LW, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("SH 21 trap", SH, 32'h21, 32'h1111, 32'h0, 1'b1, 1, 0);
        chk("mem 20 after SH 21", mword(32'h20), 32'h12EEBEEF);
`else
        do_req("LW 22 align", LW, 32'h22, 32'h0, 32'h12EEBEEF, 1'b0, 2, 0);
        do_req("SH 21 align", SH, 32'h21, 32'h1111, 32'h0, 1'b0, 3, 1);
        chk("mem 20 after SH 21", mword(32'h20), 32'h12EE1111);
        do_req("SH 20 restore", SH, 32'h20, 32'hBEEF, 32'h0, 1'b0, 3, 1);
`endif

        do_req("SW 7E range", SW, 32'h7E, 32'hA5A5A5A5, 32'h0, 1'b1, 1, 0);
        chk("mem 7C after SW 7E", mword(32'h7C), 32'h0);
        do_req("LW 80 range", LW, 32'h80, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("LW 7C edge", LW, 32'h7C, 32'h0, 32'h0, 1'b0, 2, 0);
        do_req("LB 7F edge", LB, 32'h7F, 32'h0, 32'h0, 1'b0, 2, 0);

        // Backpressure: response must hold while req_valid is waved at a busy unit.
        issue("hold", LW, 32'h20, 32'h0, 32'h12EEBEEF, 1'b0);
        wait_resp("hold", 2, 0);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_op    = SW;
            req_addr  = 32'h40;
            req_wdata = 32'hDEADBEEF;
            @(posedge clk);
            #1;
            chk("hold resp_valid", 32'(resp_valid), 32'd1);
            chk("hold resp_rdata", resp_rdata, 32'h12EEBEEF);
            chk("hold resp_err", 32'(resp_err), 32'd0);
            chk("hold req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        finish_resp("hold");
        repeat (3) @(posedge clk);
        #1;
        chk("hold no stray resp", 32'(resp_valid), 32'd0);
        chk("hold no stray write", 32'(we_cnt - we_base), 32'd0);
        chk("mem 40 untouched", mword(32'h40), 32'h0);

        // Reset while the SB is in its read phase: the write must never happen.
        req_op    = SB;
        req_addr  = 32'h30;
        req_wdata = 32'h55;
        req_valid = 1'b1;
        we_base   = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst resp_rdata", resp_rdata, 32'd0);
        chk("midrst mem_we", 32'(mem_we), 32'd0);
        chk("midrst mem_addr", mem_addr, 32'd0);
        chk("midrst mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst mem 30", mword(32'h30), 32'hCAFEF00D);
        chk("midrst writes", 32'(we_cnt - we_base), 32'd0);
        chk("midrst idle resp", 32'(resp_valid), 32'd0);
        do_req("LBU 30 post", LBU, 32'h30, 32'h0, 32'h0000000D, 1'b0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/loadstore_unit.md
Name: loadstore_unit

Overview:
CPU-side initiator for the byte-addressed, little-endian data memory (32-bit word port, combinational read, word write on clk rising edge). Accepts MIPS load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) over a valid/ready handshake and drives the memory port. Performs sign/zero extension for loads and read-modify-write for sub-word stores. Sits between the execute stage and the data memory.

Parameters:
MEM_BYTES, 128, memory size in bytes; addresses >= MEM_BYTES are errors.
ADDR_W, 32, address width of request and memory port.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept; high only in IDLE
req_op  input  3  lsu_op_t: LB=0 LH=1 LW=2 LBU=4 LHU=5 SB=6 SH=7 SW=3
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  response held until resp_ready
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load result; 0 for stores and errors
resp_err  output  1  misaligned or out-of-range access; no memory write
mem_addr  output  ADDR_W  memory byte address, always word-aligned
mem_wdata  output  32  memory write data
mem_we  output  1  memory write enable
mem_rdata  input  32  memory read data, combinational from mem_addr

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_addr=0; mem_wdata=0. Reset mid-operation abandons the access; no write is issued after reset deasserts.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: on req_valid&&req_ready latch op, addr, wdata. Address check: half ops need addr[0]=0, word ops addr[1:0]=0; addr+size > MEM_BYTES is error. Error -> RESP with resp_err=1. Otherwise LW/LB/LH/LBU/LHU -> LOAD, SW -> STORE, SB/SH -> RMW_RD.
- LOAD (1 cycle): mem_addr={addr[31:2],2'b00}, mem_we=0; select byte addr[1:0] or half addr[1]; sign-extend (LB/LH) or zero-extend (LBU/LHU); register into resp_rdata -> RESP.
- STORE (1 cycle): mem_we=1, mem_wdata=wdata -> RESP.
- RMW_RD (1 cycle): read word, merge wdata[7:0] into byte lane addr[1:0] (SB) or wdata[15:0] into half lane addr[1] (SH); register merged word -> RMW_WR.
- RMW_WR (1 cycle): mem_we=1, mem_wdata=merged -> RESP.
- RESP: resp_valid=1, held with stable rdata/err until resp_ready; then -> IDLE. resp_ready ignored outside RESP.
- mem_we is high only in STORE and RMW_WR, exactly one cycle per store.
- Latency from accept to resp_valid: loads/SW 2 cycles, SB/SH 3 cycles, errors 1 cycle.
- Back-to-back: a new request is accepted only in IDLE, so at most one access is outstanding.
- Unused op encodings are treated as errors.

Optional Feature:
LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses return resp_err=1 as above. When undefined, misalignment is not an error. Low address bits are forced to alignment (addr[0] cleared for halves, addr[1:0] for words) and the access proceeds. Out-of-range accesses are errors in both builds.

Decomposition:
Shared package lsu_pkg: lsu_op_t enum, state enum, and size/extension helpers (op_size, op_is_store, op_is_signed). One natural sub-module, lsu_lane_mux: combinational byte/half extract-extend for loads and lane merge for stores. The FSM stays in loadstore_unit.

Test Plan:
- Memory word at 0x10 = 0x8899AABB; LB addr 0x11 -> resp_rdata 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899.
- SW 0x20 data 0x12345678, then LW 0x20 -> 0x12345678; mem_we high exactly 1 cycle; latency 2.
- Word 0x20 = 0x12345678; SB 0x22 data 0xEE -> word 0x12EE5678; SH 0x20 data 0xBEEF -> word 0x12EEBEEF; latency 3, one write each.
- LW 0x22 -> with LSU_MISALIGN_TRAP_EN: resp_err=1, no mem_we; without it: returns word at 0x20. SW 0x7E (MEM_BYTES=128) -> resp_err=1 in both builds.
- Hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0; req_valid pulses are ignored.
- Assert reset during RMW_RD of SB 0x30 -> outputs return to reset values immediately; word 0x30 is unchanged.
